parking_scan_controller: RTL and testbench

- Parametrised successor of the parking-lot manager. Handles N sensed spots with synchronisation and per-spot debounce, and registers free/occupied counts.
- Time-multiplexes a 4-digit 7-segment display (two decimal digits for free spots, two for occupied) and scans an LED matrix of spots column by column.
- Adds a lot-full flag and a saturating entry-event counter.
- Sits between the raw spot sensors and the board display/matrix pins. All timing is derived from one prescaler.

---
 rtl/parking_scan_controller.sv | 179 +++++++++++++++++
 tb/tb_parking_scan_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_scan_controller.sv
`default_nettype none
// ============================================================================
// parking_scan_controller : debounced spot sensing, occupancy counts, entry
// counter, and scanned 7-segment / LED-matrix outputs.  Revision 1.0
// ============================================================================
module parking_scan_controller #(
  parameter int NUM_VAGAS     = 8,
  parameter int MATRIX_COLS   = 2,
  parameter int SCAN_DIV_BITS = 18,
  parameter int DEB_TICKS     = 4,
  parameter int ENTRY_W       = 16,
  localparam int ROWS         = NUM_VAGAS / MATRIX_COLS,
  localparam int CW           = $clog2(NUM_VAGAS + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_VAGAS-1:0]   vagasEstacionamento,
  output logic [3:0]             digitoD7S,
  output logic [6:0]             numeroD7S,
  output logic                   pontoD7S,
  output logic [MATRIX_COLS-1:0] colunaMatrizLEDS,
  output logic [ROWS-1:0]        linhaMatrizLEDS,
  output logic [CW-1:0]          totalOcupadas,
  output logic [CW-1:0]          totalLivres,
  output logic                   lotado,
  output logic [ENTRY_W-1:0]     totalEntradas
);

  localparam int DCW = $clog2(DEB_TICKS + 1);
  localparam int CIW = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1;
  localparam int SW  = ((ENTRY_W > CW) ? ENTRY_W : CW) + 1;
  localparam logic [ENTRY_W-1:0] c_entry_max = '1;

  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [NUM_VAGAS-1:0]     r_sync1, r_sync2, r_deb, w_deb_next;
  logic [DCW-1:0]           r_cnt      [NUM_VAGAS];
  logic [DCW-1:0]           w_cnt_next [NUM_VAGAS];
  logic [CW-1:0]            r_occ, r_free, w_pop, w_rise_cnt;
  logic                     r_lotado, w_tick;
  logic [ENTRY_W-1:0]       r_entries, w_entries_next;
  logic [SW-1:0]            w_entry_sum;
  logic [1:0]               r_dsel;
  logic [3:0]               r_dig, w_dig;
  logic [6:0]               r_seg, w_seg, w_occ7, w_free7;
  logic [3:0]               w_occ_t, w_occ_u, w_free_t, w_free_u;
  logic [CIW-1:0]           r_csel, w_csel_next;
  logic [MATRIX_COLS-1:0]   r_col, w_col;
  logic [ROWS-1:0]          r_row, w_row;

  function automatic logic [CW-1:0] popcount(input logic [NUM_VAGAS-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_VAGAS; i++) acc = acc + CW'(v[i]);
    return acc;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: glyph = 7'b0000001;
      4'd1: glyph = 7'b1001111;
      4'd2: glyph = 7'b0010010;
      4'd3: glyph = 7'b0000110;
      4'd4: glyph = 7'b1001100;
      4'd5: glyph = 7'b0100100;
      4'd6: glyph = 7'b0100000;
      4'd7: glyph = 7'b0001111;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign w_tick = &r_presc;
  assign w_pop  = popcount(r_deb);

  // A spot flips only after DEB_TICKS consecutive ticks of disagreement.
  always_comb begin
    w_deb_next = r_deb;
    for (int i = 0; i < NUM_VAGAS; i++) begin
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == DCW'(DEB_TICKS - 1)) w_deb_next[i] = r_sync2[i];
        else                                 w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise_cnt     = popcount(w_deb_next & ~r_deb);
  assign w_entry_sum    = SW'(r_entries) + SW'(w_rise_cnt);
  assign w_entries_next = (w_entry_sum > SW'(c_entry_max)) ? c_entry_max
                                                           : w_entry_sum[ENTRY_W-1:0];

  assign w_occ7   = 7'(r_occ);
  assign w_free7  = 7'(r_free);
  assign w_occ_t  = 4'(w_occ7 / 7'd10);
  assign w_occ_u  = 4'(w_occ7 % 7'd10);
  assign w_free_t = 4'(w_free7 / 7'd10);
  assign w_free_u = 4'(w_free7 % 7'd10);

  always_comb begin
    w_dig = 4'b1111;
    w_seg = 7'b1111111;
    case (r_dsel)
      2'd0: begin
        w_dig = 4'b1110;
        w_seg = glyph(w_occ_u);
      end
      2'd1: begin
        w_dig = 4'b1101;
        w_seg = (w_occ_t == 4'd0) ? 7'b1111111 : glyph(w_occ_t);
      end
      2'd2: begin
        w_dig = 4'b1011;
        w_seg = glyph(w_free_u);
      end
      default: begin
        w_dig = 4'b0111;
        w_seg = (w_free_t == 4'd0) ? 7'b1111111 : glyph(w_free_t);
      end
    endcase
  end

  always_comb begin
    w_row = '1;
    for (int r = 0; r < ROWS; r++) w_row[r] = ~r_deb[r*MATRIX_COLS + int'(r_csel)];
    w_col       = ~(MATRIX_COLS'(1) << r_csel);
    w_csel_next = (r_csel == CIW'(MATRIX_COLS - 1)) ? '0 : r_csel + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc   <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      for (int i = 0; i < NUM_VAGAS; i++) r_cnt[i] <= '0;
      r_occ     <= '0;
      r_free    <= CW'(NUM_VAGAS);
      r_lotado  <= 1'b0;
      r_entries <= '0;
      r_dsel    <= '0;
      r_dig     <= 4'b1111;
      r_seg     <= 7'b1111111;
      r_csel    <= '0;
      r_col     <= '1;
      r_row     <= '1;
    end else begin
      r_presc  <= r_presc + 1'b1;
      r_sync1  <= vagasEstacionamento;
      r_sync2  <= r_sync1;
      r_occ    <= w_pop;
      r_free   <= CW'(NUM_VAGAS) - w_pop;
      r_lotado <= (w_pop == CW'(NUM_VAGAS));
      if (w_tick) begin
        r_deb     <= w_deb_next;
        for (int i = 0; i < NUM_VAGAS; i++) r_cnt[i] <= w_cnt_next[i];
        r_entries <= w_entries_next;
        r_dsel    <= r_dsel + 2'd1;
        r_dig     <= w_dig;
        r_seg     <= w_seg;
        r_csel    <= w_csel_next;
        r_col     <= w_col;
        r_row     <= w_row;
      end
    end
  end

  assign digitoD7S        = r_dig;
  assign numeroD7S        = r_seg;
  assign pontoD7S         = 1'b1;
  assign colunaMatrizLEDS = r_col;
  assign linhaMatrizLEDS  = r_row;
  assign totalOcupadas    = r_occ;
  assign totalLivres      = r_free;
  assign lotado           = r_lotado;
  assign totalEntradas    = r_entries;

endmodule
`default_nettype wire

// File: tb/tb_parking_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_parking_scan_controller : scoreboard bench for parking_scan_controller.
// Revision 1.0
// ============================================================================
module tb_parking_scan_controller;

  typedef struct packed {logic [3:0] dig; logic [6:0] seg;} disp_t;
  typedef struct packed {logic [3:0] occ; logic [3:0] fre; logic lot; logic [15:0] ent;} cnt_t;

  logic CLK = 1'b0;
  logic RST, rst_e;
  logic [7:0]  sens, sens_e;
  logic [23:0] sens24;

  logic [3:0] dig, dig24, dig_e;
  logic [6:0] seg, seg24, seg_e;
  logic       pto, pto24, pto_e, lot, lot24, lot_e;
  logic [1:0] col, col_e;
  logic [3:0] col24;
  logic [3:0] row, row_e, occ, fre, occ_e, fre_e;
  logic [5:0] row24;
  logic [4:0] occ24, fre24;
  logic [15:0] ent, ent24;
  logic [2:0] ent_e;

  int n_tests = 0;
  int n_fail  = 0;
  int clk_cnt = 0;

  disp_t q_disp[$];
  cnt_t  q_cnt[$];
  int    q_int[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RST)
    if (RST) clk_cnt <= 0;
    else     clk_cnt <= clk_cnt + 1;

  parking_scan_controller #(.NUM_VAGAS(8), .MATRIX_COLS(2), .SCAN_DIV_BITS(2),
                            .DEB_TICKS(2), .ENTRY_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .vagasEstacionamento(sens),
    .digitoD7S(dig), .numeroD7S(seg), .pontoD7S(pto),
    .colunaMatrizLEDS(col), .linhaMatrizLEDS(row),
    .totalOcupadas(occ), .totalLivres(fre), .lotado(lot), .totalEntradas(ent));

  parking_scan_controller #(.NUM_VAGAS(24), .MATRIX_COLS(4), .SCAN_DIV_BITS(2),
                            .DEB_TICKS(2), .ENTRY_W(16)) u_dut24 (
    .CLK(CLK), .RST(RST), .vagasEstacionamento(sens24),
    .digitoD7S(dig24), .numeroD7S(seg24), .pontoD7S(pto24),
    .colunaMatrizLEDS(col24), .linhaMatrizLEDS(row24),
    .totalOcupadas(occ24), .totalLivres(fre24), .lotado(lot24), .totalEntradas(ent24));

  parking_scan_controller #(.NUM_VAGAS(8), .MATRIX_COLS(2), .SCAN_DIV_BITS(2),
                            .DEB_TICKS(2), .ENTRY_W(3)) u_dut_e (
    .CLK(CLK), .RST(rst_e), .vagasEstacionamento(sens_e),
    .digitoD7S(dig_e), .numeroD7S(seg_e), .pontoD7S(pto_e),
    .colunaMatrizLEDS(col_e), .linhaMatrizLEDS(row_e),
    .totalOcupadas(occ_e), .totalLivres(fre_e), .lotado(lot_e), .totalEntradas(ent_e));

  function automatic logic [6:0] glyph_tb(int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic disp_t exp_disp(int d, int o, int f);
    disp_t e;
    case (d)
      0: begin e.dig = 4'b1110; e.seg = glyph_tb(o % 10); end
      1: begin e.dig = 4'b1101; e.seg = (o / 10 == 0) ? 7'h7F : glyph_tb(o / 10); end
      2: begin e.dig = 4'b1011; e.seg = glyph_tb(f % 10); end
      default: begin e.dig = 4'b0111; e.seg = (f / 10 == 0) ? 7'h7F : glyph_tb(f / 10); end
    endcase
    return e;
  endfunction

  // Lands 1 time unit after the next scan-tick edge (every 4th clock).
  task automatic wait_tick();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (clk_cnt % 4 == 0) break;
    end
  endtask

  task automatic test_reset();
    cnt_t c_obs, c_exp;
    RST = 1'b1; rst_e = 1'b1;
    sens = '0; sens_e = '0; sens24 = 24'h001FFF;
    repeat (2) @(posedge CLK); #1;
    n_tests++;
    if ({dig, seg, pto} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL reset_disp: got %b expected %b", {dig, seg, pto}, {4'hF, 7'h7F, 1'b1});
    end
    n_tests++;
    if ({col, row} !== 6'h3F) begin
      n_fail++; $display("FAIL reset_matrix: got %b expected %b", {col, row}, 6'h3F);
    end
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd0});
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL reset_counts: got %h expected %h", c_obs, c_exp);
    end
    n_tests++;
    if ({dig24, seg24, pto24, col24, row24, occ24, fre24, lot24, ent24} !==
        {4'hF, 7'h7F, 1'b1, 4'hF, 6'h3F, 5'd0, 5'd24, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL reset_dut24: got %h expected %h",
        {dig24, seg24, pto24, col24, row24, occ24, fre24, lot24, ent24},
        {4'hF, 7'h7F, 1'b1, 4'hF, 6'h3F, 5'd0, 5'd24, 1'b0, 16'd0});
    end
    @(negedge CLK);
    RST = 1'b0; rst_e = 1'b0;
    repeat (3) @(posedge CLK); #1;
    n_tests++;
    if ({dig, seg} !== {4'hF, 7'h7F}) begin
      n_fail++; $display("FAIL pre_tick_disp: got %b expected %b", {dig, seg}, {4'hF, 7'h7F});
    end
  endtask

  task automatic test_idle_display();
    disp_t d_obs, d_exp;
    for (int i = 0; i < 4; i++) q_disp.push_back(exp_disp(i, 0, 8));
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      d_obs = {dig, seg}; d_exp = q_disp.pop_front();
      n_tests++;
      if (d_obs !== d_exp) begin
        n_fail++; $display("FAIL idle_digit%0d: got %b expected %b", i, d_obs, d_exp);
      end
    end
  endtask

  task automatic test_accept();
    cnt_t c_obs, c_exp;
    int   c;
    logic [5:0] m_exp;
    logic [7:0] model_deb;
    sens[3] = 1'b1;
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd0});
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd1});
    q_cnt.push_back('{occ: 4'd1, fre: 4'd7, lot: 1'b0, ent: 16'd1});
    wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL accept_tick1: got %h expected %h", c_obs, c_exp);
    end
    wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL accept_tick2: got %h expected %h", c_obs, c_exp);
    end
    @(posedge CLK); #1;
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL accept_latency: got %h expected %h", c_obs, c_exp);
    end
    model_deb = 8'h08;
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      c = (clk_cnt / 4 - 1) % 2;
      m_exp[5:4] = ~(2'b01 << c);
      for (int r = 0; r < 4; r++) m_exp[r] = ~model_deb[r*2 + c];
      n_tests++;
      if ({col, row} !== m_exp) begin
        n_fail++; $display("FAIL matrix_col%0d: got %b expected %b", c, {col, row}, m_exp);
      end
    end
  endtask

  task automatic test_glitch();
    cnt_t c_obs, c_exp;
    sens[5] = 1'b1;
    q_cnt.push_back('{occ: 4'd1, fre: 4'd7, lot: 1'b0, ent: 16'd1});
    wait_tick();
    sens[5] = 1'b0;
    repeat (3) wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL glitch_counts: got %h expected %h", c_obs, c_exp);
    end
  endtask

  task automatic test_full();
    cnt_t  c_obs, c_exp;
    disp_t d_obs, d_exp;
    int    k;
    sens = 8'h00;
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd1});
    repeat (3) wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL release_counts: got %h expected %h", c_obs, c_exp);
    end
    sens = 8'hFF;
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd1});
    q_cnt.push_back('{occ: 4'd0, fre: 4'd8, lot: 1'b0, ent: 16'd9});
    q_cnt.push_back('{occ: 4'd8, fre: 4'd0, lot: 1'b1, ent: 16'd9});
    wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL full_tick1: got %h expected %h", c_obs, c_exp);
    end
    wait_tick();
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL full_tick2: got %h expected %h", c_obs, c_exp);
    end
    @(posedge CLK); #1;
    c_obs = {occ, fre, lot, ent}; c_exp = q_cnt.pop_front();
    n_tests++;
    if (c_obs !== c_exp) begin
      n_fail++; $display("FAIL full_counts: got %h expected %h", c_obs, c_exp);
    end
    k = clk_cnt / 4 + 1;
    for (int i = 0; i < 4; i++) q_disp.push_back(exp_disp((k - 1 + i) % 4, 8, 0));
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      d_obs = {dig, seg}; d_exp = q_disp.pop_front();
      n_tests++;
      if (d_obs !== d_exp) begin
        n_fail++; $display("FAIL full_disp%0d: got %b expected %b", i, d_obs, d_exp);
      end
    end
  endtask

  task automatic test_wide();
    disp_t d_obs, d_exp;
    int    k;
    n_tests++;
    if ({occ24, fre24, lot24, ent24} !== {5'd13, 5'd11, 1'b0, 16'd13}) begin
      n_fail++; $display("FAIL wide_counts: got %h expected %h",
        {occ24, fre24, lot24, ent24}, {5'd13, 5'd11, 1'b0, 16'd13});
    end
    k = clk_cnt / 4 + 1;
    for (int i = 0; i < 4; i++) q_disp.push_back(exp_disp((k - 1 + i) % 4, 13, 11));
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      d_obs = {dig24, seg24}; d_exp = q_disp.pop_front();
      n_tests++;
      if (d_obs !== d_exp) begin
        n_fail++; $display("FAIL wide_disp%0d: got %b expected %b", i, d_obs, d_exp);
      end
    end
  endtask

  task automatic test_saturate();
    int e;
    for (int k = 1; k <= 9; k++) begin
      sens_e[0] = 1'b1;
      q_int.push_back((k > 7) ? 7 : k);
      repeat (2) wait_tick();
      e = q_int.pop_front();
      n_tests++;
      if (ent_e !== 3'(e)) begin
        n_fail++; $display("FAIL sat_entries%0d: got %0d expected %0d", k, ent_e, e);
      end
      sens_e[0] = 1'b0;
      repeat (2) wait_tick();
    end
  endtask

  task automatic test_async_reset();
    sens_e[1] = 1'b1;
    wait_tick();
    #1 rst_e = 1'b1;
    #1;
    n_tests++;
    if ({dig_e, seg_e, pto_e, col_e, row_e} !== {4'hF, 7'h7F, 1'b1, 2'b11, 4'hF}) begin
      n_fail++; $display("FAIL async_outputs: got %b expected %b",
        {dig_e, seg_e, pto_e, col_e, row_e}, {4'hF, 7'h7F, 1'b1, 2'b11, 4'hF});
    end
    n_tests++;
    if ({occ_e, fre_e, lot_e, ent_e} !== {4'd0, 4'd8, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL async_counts: got %h expected %h",
        {occ_e, fre_e, lot_e, ent_e}, {4'd0, 4'd8, 1'b0, 3'd0});
    end
    @(negedge CLK);
    rst_e = 1'b0;
    wait_tick();
    n_tests++;
    if ({occ_e, ent_e} !== {4'd0, 3'd0}) begin
      n_fail++; $display("FAIL abort_debounce: got %h expected %h", {occ_e, ent_e}, {4'd0, 3'd0});
    end
    wait_tick();
    n_tests++;
    if (ent_e !== 3'd1) begin
      n_fail++; $display("FAIL post_reset_entry: got %0d expected 1", ent_e);
    end
  endtask

  initial begin
    test_reset();
    test_idle_display();
    test_accept();
    test_glitch();
    test_full();
    test_wide();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
